// File: rtl/booth_mac_collector.sv
// -----------------------------------------------------------------------------
// booth_mac_collector
//   Collects products from a Booth multiplier. Each rising edge of the
//   multiplier's ready level captures one product. The product is
//   sign-extended and added into a saturating signed accumulator. The pair
//   {product, running sum} is then queued in a small FIFO, which a
//   valid/ready port drains. The FIFO head is registered (not fall-through),
//   so a pushed entry reaches the head one cycle after the capture edge.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   prod_in      signed product from the multiplier
//   prod_rdy     multiplier ready level; a low->high transition captures
//   acc_clear    synchronous accumulator clear (pulse or level)
//   out_valid    head entry present
//   out_ready    consumer accepts the head entry
//   out_prod     head entry: captured product
//   out_acc      head entry: accumulator value after that product
//   fifo_count   current FIFO occupancy
//   sat          sticky saturation flag since the last clear or reset
//   drop         one-cycle pulse: a product was lost because the FIFO was full
// -----------------------------------------------------------------------------
module booth_mac_collector #(
  parameter int OPERAND_BITS = 4,
  parameter int ACC_BITS     = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [2*OPERAND_BITS-1:0]       prod_in,
  input  logic                            prod_rdy,
  input  logic                            acc_clear,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*OPERAND_BITS-1:0]       out_prod,
  output logic [ACC_BITS-1:0]             out_acc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            sat,
  output logic                            drop
);

  localparam int PW = 2 * OPERAND_BITS;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  // State
  logic                rdy_q;
  logic [ACC_BITS-1:0] acc_q,       acc_d;
  logic                sat_q,       sat_d;
  logic                drop_q,      drop_d;
  logic [AW-1:0]       wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]       count_q,     count_d;
  logic                out_valid_q, out_valid_d;
  logic [PW-1:0]       out_prod_q,  out_prod_d;
  logic [ACC_BITS-1:0] out_acc_q,   out_acc_d;

  logic [PW-1:0]       prod_mem [FIFO_DEPTH];
  logic [ACC_BITS-1:0] acc_mem  [FIFO_DEPTH];

  // Datapath / control
  logic                cap, pop, push, full, clamp;
  logic [ACC_BITS-1:0] base, result;
  logic [ACC_BITS:0]   sum;
  logic [CW-1:0]       visible;

  always_comb begin
    cap  = prod_rdy & ~rdy_q;
    pop  = out_valid_q & out_ready;
    full = (count_q == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    push = cap & (~full | pop);

    base = acc_clear ? '0 : acc_q;
    // One guard bit: overflow shows up as a disagreement of the top two bits.
    sum    = {base[ACC_BITS-1], base}
           + {{(ACC_BITS+1-PW){prod_in[PW-1]}}, prod_in};
    clamp  = (sum[ACC_BITS] != sum[ACC_BITS-1]);
    result = clamp ? (sum[ACC_BITS] ? ACC_MIN : ACC_MAX) : sum[ACC_BITS-1:0];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    acc_d = acc_q;
    sat_d = sat_q;
    if (push) begin
      acc_d = result;
      sat_d = (acc_clear ? 1'b0 : sat_q) | clamp;
    end else if (acc_clear) begin
      acc_d = '0;
      sat_d = 1'b0;
    end

    drop_d   = cap & ~push;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    // The head register only sees entries already in memory before this edge,
    // which gives a pushed entry its one cycle of latency to the head.
    visible     = count_q - CW'(pop);
    out_valid_d = (visible != '0);
    out_prod_d  = out_prod_q;
    out_acc_d   = out_acc_q;
    if (visible != '0) begin
      out_prod_d = prod_mem[rd_ptr_d];
      out_acc_d  = acc_mem[rd_ptr_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b1;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      out_acc_q   <= '0;
    end else begin
      rdy_q       <= prod_rdy;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
      out_acc_q   <= out_acc_d;
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      prod_mem[wr_ptr_q] <= prod_in;
      acc_mem[wr_ptr_q]  <= result;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_prod   = out_prod_q;
  assign out_acc    = out_acc_q;
  assign fifo_count = count_q;
  assign sat        = sat_q;
  assign drop       = drop_q;

endmodule

// File: tb/tb_booth_mac_collector.sv
// -----------------------------------------------------------------------------
// tb_booth_mac_collector
//   Two instances share one set of stimulus: dut (ACC_BITS=16) and dut8
//   (ACC_BITS=8, used for the saturation sequences). Inputs change on the
//   falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_booth_mac_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] prod_in;
  logic       prod_rdy, acc_clear, out_ready;

  logic        out_valid,  sat,  drop;
  logic [7:0]  out_prod;
  logic [15:0] out_acc;
  logic [2:0]  fifo_count;

  logic        out_valid8, sat8, drop8;
  logic [7:0]  out_prod8;
  logic [7:0]  out_acc8;
  logic [2:0]  fifo_count8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_mac_collector #(.OPERAND_BITS(4), .ACC_BITS(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_rdy(prod_rdy),
    .acc_clear(acc_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_acc(out_acc), .fifo_count(fifo_count),
    .sat(sat), .drop(drop));

  booth_mac_collector #(.OPERAND_BITS(4), .ACC_BITS(8), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_rdy(prod_rdy),
    .acc_clear(acc_clear), .out_valid(out_valid8), .out_ready(out_ready),
    .out_prod(out_prod8), .out_acc(out_acc8), .fifo_count(fifo_count8),
    .sat(sat8), .drop(drop8));

  typedef struct {
    logic [7:0]  prod;
    logic        clr;
    logic [15:0] exp_acc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; prod_in = '0; prod_rdy = 1'b0; acc_clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Rising edge of prod_rdy; the capture edge is the next posedge. Returns at
  // the falling edge just after it, with prod_rdy back low.
  task automatic pulse(input logic [7:0] p, input logic clr);
    prod_in = p; prod_rdy = 1'b1; acc_clear = clr;
    @(negedge clk);
    prod_rdy = 1'b0; acc_clear = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    // Running sum at 16 bits; entry 4 clears before adding.
    vecs[0] = '{8'hFA, 1'b0, 16'hFFFA};  // -6
    vecs[1] = '{8'h0F, 1'b0, 16'h0009};  // -6+15 = 9
    vecs[2] = '{8'h80, 1'b0, 16'hFF89};  // 9-128 = -119
    vecs[3] = '{8'h7F, 1'b0, 16'h0008};  // -119+127 = 8
    vecs[4] = '{8'h03, 1'b1, 16'h0003};  // clear coincident with capture
    vecs[5] = '{8'hFE, 1'b0, 16'h0001};  // 3-2 = 1

    // ---- reset state ----
    do_reset();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_count",     32'(fifo_count), 0);
    check("rst_out_prod",  32'(out_prod), 0);
    check("rst_out_acc",   32'(out_acc), 0);
    check("rst_sat",       32'(sat), 0);
    check("rst_drop",      32'(drop), 0);

    // ---- table: capture latency, head contents, accumulation ----
    for (int i = 0; i < 6; i++) begin
      pulse(vecs[i].prod, vecs[i].clr);
      check($sformatf("v%0d_valid_T", i), 32'(out_valid), 0);
      check($sformatf("v%0d_count_T", i), 32'(fifo_count), 1);
      @(negedge clk);
      check($sformatf("v%0d_valid_T1", i), 32'(out_valid), 1);
      check($sformatf("v%0d_prod", i), 32'(out_prod), 32'(vecs[i].prod));
      check($sformatf("v%0d_acc", i),  32'(out_acc),  32'(vecs[i].exp_acc));
      pop();
      check($sformatf("v%0d_empty", i), 32'(fifo_count), 0);
    end
    check("table_sat", 32'(sat), 0);

    // ---- prod_rdy high at reset exit is not a capture ----
    rst_n = 1'b0; prod_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rdy_at_reset_count", 32'(fifo_count), 0);
    prod_rdy = 1'b0;
    @(negedge clk);

    // ---- held-high prod_rdy captures exactly once ----
    do_reset();
    prod_in = 8'h05; prod_rdy = 1'b1;
    repeat (10) @(negedge clk);
    prod_rdy = 1'b0;
    @(negedge clk);
    check("held_count", 32'(fifo_count), 1);
    check("held_acc",   32'(out_acc), 32'h5);

    // ---- saturation on the 8-bit instance ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(8'h7F, 1'b0);
      check($sformatf("sat8_flag_%0d", i), 32'(sat8), (i >= 1) ? 1 : 0);
      @(negedge clk);
      check($sformatf("sat8_acc_%0d", i), 32'(out_acc8), 32'h7F);
      pop();
    end
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    check("sat8_cleared", 32'(sat8), 0);
    pulse(8'h01, 1'b0);
    @(negedge clk);
    check("sat8_after_clr_acc", 32'(out_acc8), 32'h01);
    pop();
    pulse(8'h80, 1'b0);
    check("sat8_neg_noclamp", 32'(sat8), 0);
    @(negedge clk);
    check("sat8_neg_acc0", 32'(out_acc8), 32'h81);  // 1-128 = -127
    pop();
    pulse(8'h80, 1'b0);
    check("sat8_neg_clamp", 32'(sat8), 1);
    @(negedge clk);
    check("sat8_neg_acc1", 32'(out_acc8), 32'h80);  // clamps to -128
    pop();

    // ---- full FIFO: 5th capture dropped ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(8'(i + 1), 1'b0);
      check($sformatf("full_drop_%0d", i), 32'(drop), (i == 4) ? 1 : 0);
      @(negedge clk);
    end
    check("full_drop_gone", 32'(drop), 0);
    check("full_count", 32'(fifo_count), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_drain_prod_%0d", i), 32'(out_prod), 32'(i + 1));
      check($sformatf("full_drain_acc_%0d", i), 32'(out_acc), 32'((i + 1) * (i + 2) / 2));
      pop();
    end
    check("full_drained", 32'(fifo_count), 0);
    pulse(8'h01, 1'b0);
    @(negedge clk);
    check("full_acc_unchanged", 32'(out_acc), 32'd11);  // 10+1, dropped 5 absent
    pop();

    // ---- full FIFO with coincident pop and capture ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(8'(i + 1), 1'b0);
      @(negedge clk);
    end
    prod_in = 8'h05; prod_rdy = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    prod_rdy = 1'b0; out_ready = 1'b0;
    check("popush_drop",  32'(drop), 0);
    check("popush_count", 32'(fifo_count), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("popush_prod_%0d", i), 32'(out_prod), 32'(i + 2));
      check($sformatf("popush_acc_%0d", i), 32'(out_acc), 32'((i + 2) * (i + 3) / 2));
      pop();
    end
    check("popush_empty", 32'(out_valid), 0);

    // ---- async reset mid-drain ----
    do_reset();
    pulse(8'h03, 1'b0);
    @(negedge clk);
    pulse(8'h04, 1'b0);
    @(negedge clk);
    pop();
    check("mid_valid_before", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid_after",  32'(out_valid), 0);
    check("mid_count_after",  32'(fifo_count), 0);
    check("mid_acc_after",    32'(out_acc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
